// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared state encoding and index-width helpers for the FIFO write arbiter.
package fifo_wr_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_PAD   = 2'd2
  } arb_state_e;

  function automatic int unsigned src_width(input int unsigned n_req);
    return (n_req > 1) ? $clog2(n_req) : 1;
  endfunction

  function automatic int unsigned beat_width(input int unsigned ratio);
    return (ratio > 1) ? $clog2(ratio) : 1;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Producer request bus, FIFO write port and word-completion report of the arbiter.
interface fifo_wr_arbiter_if #(
  parameter int N_REQ   = 4,
  parameter int W_WIDTH = 16
);
  import fifo_wr_arbiter_pkg::*;

  localparam int SRC_W = src_width(N_REQ);

  logic [N_REQ-1:0]         req_valid;
  logic [N_REQ*W_WIDTH-1:0] req_data;
  logic [N_REQ-1:0]         req_ready;
  logic                     fifo_wr_en;
  logic [W_WIDTH-1:0]       fifo_wr_data;
  logic                     fifo_full;
  logic                     word_done;
  logic [SRC_W-1:0]         word_src;
  logic                     word_pad;

  // master: the arbiter itself
  modport master (
    input  req_valid, req_data, fifo_full,
    output req_ready, fifo_wr_en, fifo_wr_data, word_done, word_src, word_pad
  );

  // slave: producers + FIFO side
  modport slave (
    output req_valid, req_data, fifo_full,
    input  req_ready, fifo_wr_en, fifo_wr_data, word_done, word_src, word_pad
  );

endinterface

// File: rtl/fifo_wr_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first valid index after last_i, wrapping; last_i is lowest priority.
module rr_arbiter
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int N_REQ = 4,
  localparam int SRC_W = src_width(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [SRC_W-1:0] last_i,
  output logic [SRC_W-1:0] grant_o,
  output logic             any_valid_o
);

  logic [N_REQ-1:0] upper;

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_upper
      assign upper[gi] = req_i[gi] && (gi > int'(last_i));
    end
  endgenerate

  // Lowest requester above last wins; otherwise wrap to the lowest requester overall.
  always_comb begin
    grant_o = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req_i[i]) grant_o = SRC_W'(i);
    end
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (upper[i]) grant_o = SRC_W'(i);
    end
  end

  assign any_valid_o = |req_i;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst write arbiter in front of the width-converting FIFO.
// Optional stall timeout with zero padding: define MWSR_ARB_TIMEOUT_EN.
module fifo_wr_arbiter
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int W_WIDTH = 16,
  parameter int RATIO   = 2,
  parameter int TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  fifo_wr_arbiter_if.master  bus
);

  localparam int SRC_W  = src_width(N_REQ);
  localparam int BEAT_W = beat_width(RATIO);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(RATIO - 1);

  arb_state_e         state_q, state_d;
  logic [SRC_W-1:0]   grant_q, grant_d;
  logic [SRC_W-1:0]   last_q, last_d;
  logic [BEAT_W-1:0]  beat_q, beat_d;
  logic               done_q, done_d;
  logic [SRC_W-1:0]   src_q, src_d;

`ifdef MWSR_ARB_TIMEOUT_EN
  localparam int STALL_W = src_width(TIMEOUT + 1);
  logic [STALL_W-1:0] stall_q, stall_d;
  logic               pad_q, pad_d;
`endif

  logic [W_WIDTH-1:0] data_arr [N_REQ];
  logic [SRC_W-1:0]   arb_last, arb_grant;
  logic               arb_any;
  logic [N_REQ-1:0]   ready_c;
  logic               wr_en_c;
  logic [W_WIDTH-1:0] wr_data_c;
  logic               word_end;

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_slice
      assign data_arr[gi] = bus.req_data[(gi+1)*W_WIDTH-1 -: W_WIDTH];
    end
  endgenerate

  // At word completion the finishing grant becomes the new priority origin.
  assign arb_last = (state_q == ST_IDLE) ? last_q : grant_q;

  rr_arbiter #(.N_REQ(N_REQ)) u_rr (
    .req_i       (bus.req_valid),
    .last_i      (arb_last),
    .grant_o     (arb_grant),
    .any_valid_o (arb_any)
  );

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    beat_d    = beat_q;
    done_d    = 1'b0;
    src_d     = src_q;
    ready_c   = '0;
    wr_en_c   = 1'b0;
    wr_data_c = '0;
    word_end  = 1'b0;
`ifdef MWSR_ARB_TIMEOUT_EN
    stall_d   = stall_q;
    pad_d     = pad_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (arb_any) begin
          grant_d = arb_grant;
          beat_d  = '0;
          state_d = ST_BURST;
`ifdef MWSR_ARB_TIMEOUT_EN
          stall_d = '0;
`endif
        end
      end

      ST_BURST: begin
        ready_c[grant_q] = !bus.fifo_full;
        wr_en_c          = bus.req_valid[grant_q] && !bus.fifo_full;
        wr_data_c        = data_arr[grant_q];
        if (wr_en_c) begin
`ifdef MWSR_ARB_TIMEOUT_EN
          stall_d = '0;
`endif
          if (beat_q == LAST_BEAT) word_end = 1'b1;
          else                     beat_d   = beat_q + 1'b1;
        end
`ifdef MWSR_ARB_TIMEOUT_EN
        // A full FIFO is not the producer's fault, so it never counts toward the timeout.
        else if (!bus.req_valid[grant_q] && !bus.fifo_full && beat_q != '0) begin
          stall_d = stall_q + 1'b1;
          if (stall_d == STALL_W'(TIMEOUT)) state_d = ST_PAD;
        end
`endif
      end

`ifdef MWSR_ARB_TIMEOUT_EN
      ST_PAD: begin
        wr_en_c = !bus.fifo_full;
        if (wr_en_c) begin
          if (beat_q == LAST_BEAT) word_end = 1'b1;
          else                     beat_d   = beat_q + 1'b1;
        end
      end
`endif

      default: state_d = ST_IDLE;
    endcase

    if (word_end) begin
      last_d = grant_q;
      done_d = 1'b1;
      src_d  = grant_q;
      beat_d = '0;
`ifdef MWSR_ARB_TIMEOUT_EN
      pad_d   = (state_q == ST_PAD);
      stall_d = '0;
`endif
      if (arb_any) begin
        grant_d = arb_grant;
        state_d = ST_BURST;
      end else begin
        state_d = ST_IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      last_q  <= SRC_W'(N_REQ - 1);
      beat_q  <= '0;
      done_q  <= 1'b0;
      src_q   <= '0;
`ifdef MWSR_ARB_TIMEOUT_EN
      stall_q <= '0;
      pad_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      beat_q  <= beat_d;
      done_q  <= done_d;
      src_q   <= src_d;
`ifdef MWSR_ARB_TIMEOUT_EN
      stall_q <= stall_d;
      pad_q   <= pad_d;
`endif
    end
  end

  assign bus.req_ready    = ready_c;
  assign bus.fifo_wr_en   = wr_en_c;
  assign bus.fifo_wr_data = wr_data_c;
  assign bus.word_done    = done_q;
  assign bus.word_src     = src_q;
`ifdef MWSR_ARB_TIMEOUT_EN
  assign bus.word_pad     = pad_q;
`else
  assign bus.word_pad     = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: directed scenarios plus random traffic against a cycle-level model.
module tb_fifo_wr_arbiter;

  localparam int N       = 4;
  localparam int W       = 16;
  localparam int RATIO   = 2;
  localparam int TIMEOUT = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fifo_wr_arbiter_if #(.N_REQ(N), .W_WIDTH(W)) bus ();

  fifo_wr_arbiter #(.N_REQ(N), .W_WIDTH(W), .RATIO(RATIO), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [N-1:0]   drv_valid;
  logic [W-1:0]   drv_data [N];
  logic           drv_full;
  logic [N*W-1:0] drv_packed;

  always_comb begin
    drv_packed = '0;
    for (int i = 0; i < N; i++) drv_packed[i*W +: W] = drv_data[i];
  end
  assign bus.req_valid = drv_valid;
  assign bus.req_data  = drv_packed;
  assign bus.fifo_full = drv_full;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // Model of the arbiter in terms of "who owns the port and how many beats they have delivered".
  int m_owner, m_beat, m_last, m_src, m_stall;
  bit m_done, m_pad, m_padmode;

  // Transaction logs filled by tick()
  logic [W-1:0] wr_data_q[$];
  int           wr_src_q[$];
  int           wr_cyc_q[$];
  int           done_src_q[$];
  bit           done_pad_q[$];
  logic [N-1:0] acc;

  function automatic int rr_pick(input int from, input logic [N-1:0] v);
    for (int k = 1; k <= N; k++) begin
      if (v[(from + k) % N]) return (from + k) % N;
    end
    return -1;
  endfunction

  function automatic int src_of(input logic [N-1:0] r);
    for (int i = 0; i < N; i++) if (r[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1; m_beat = 0; m_last = N - 1; m_src = 0; m_stall = 0;
    m_done = 0; m_pad = 0; m_padmode = 0;
  endtask

  task automatic clear_logs();
    wr_data_q.delete(); wr_src_q.delete(); wr_cyc_q.delete();
    done_src_q.delete(); done_pad_q.delete();
  endtask

  // One clock: compare every output against the model mid-cycle, then advance the model at the edge.
  task automatic tick();
    logic [N-1:0] e_ready;
    logic         e_en;
    logic [W-1:0] e_data;
    bit           n_done;
    @(negedge clk);
    cyc++;
    e_ready = '0; e_en = 1'b0; e_data = '0;
    if (m_owner >= 0) begin
      if (m_padmode) begin
        e_en = !drv_full;
      end else begin
        if (!drv_full) e_ready[m_owner] = 1'b1;
        e_en   = drv_valid[m_owner] && !drv_full;
        e_data = drv_data[m_owner];
      end
    end
    n_vec++;
    if (bus.req_ready !== e_ready || bus.fifo_wr_en !== e_en ||
        (e_en && bus.fifo_wr_data !== e_data) || bus.word_done !== m_done ||
        bus.word_src !== 2'(m_src) || bus.word_pad !== m_pad) begin
      n_err++;
      $display("FAIL cycle_outputs cyc=%0d got rdy=%b en=%b data=%h done=%b src=%0d pad=%b, expected rdy=%b en=%b data=%h done=%b src=%0d pad=%b",
               cyc, bus.req_ready, bus.fifo_wr_en, bus.fifo_wr_data, bus.word_done, bus.word_src, bus.word_pad,
               e_ready, e_en, e_data, m_done, m_src, m_pad);
    end
    if (bus.fifo_wr_en === 1'b1) begin
      wr_data_q.push_back(bus.fifo_wr_data);
      wr_src_q.push_back(src_of(bus.req_ready));
      wr_cyc_q.push_back(cyc);
    end
    if (bus.word_done === 1'b1) begin
      done_src_q.push_back(int'(bus.word_src));
      done_pad_q.push_back(bus.word_pad);
      $display("cyc %0d: word from producer %0d pad=%0d", cyc, bus.word_src, bus.word_pad);
    end
    acc = bus.req_ready & drv_valid;

    @(posedge clk);
    n_done = 0;
    if (m_owner < 0) begin
      m_owner = rr_pick(m_last, drv_valid);
      m_beat  = 0;
      m_stall = 0;
    end else if (e_en) begin
      m_stall = 0;
      m_beat++;
      if (m_beat == RATIO) begin
        n_done    = 1;
        m_src     = m_owner;
        m_pad     = m_padmode;
        m_last    = m_owner;
        m_padmode = 0;
        m_beat    = 0;
        m_owner   = rr_pick(m_owner, drv_valid);
      end
    end
`ifdef MWSR_ARB_TIMEOUT_EN
    else if (!m_padmode && m_beat > 0 && !drv_valid[m_owner] && !drv_full) begin
      m_stall++;
      if (m_stall == TIMEOUT) m_padmode = 1;
    end
`endif
    m_done = n_done;
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    drv_valid = '0; drv_full = 1'b0;
    for (int i = 0; i < N; i++) drv_data[i] = '0;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    clear_logs();
  endtask

  task automatic test_reset();
    apply_reset();
    n_vec++;
    if (bus.req_ready !== '0 || bus.fifo_wr_en !== 1'b0 || bus.word_done !== 1'b0 ||
        bus.word_src !== '0 || bus.word_pad !== 1'b0) begin
      n_err++;
      $display("FAIL reset_values got rdy=%b en=%b done=%b src=%0d pad=%b, expected all zero",
               bus.req_ready, bus.fifo_wr_en, bus.word_done, bus.word_src, bus.word_pad);
    end
    tick();
    tick();
  endtask

  task automatic test_single_producer();
    logic [W-1:0] list [4];
    int idx;
    int start;
    list[0] = 16'h00A1; list[1] = 16'h00A2; list[2] = 16'h00A3; list[3] = 16'h00A4;
    apply_reset();
    idx = 0;
    drv_valid = 4'b0100;
    drv_data[2] = list[0];
    start = cyc;
    for (int t = 0; t < 10; t++) begin
      tick();
      if (acc[2]) idx++;
      if (idx < 4) drv_data[2] = list[idx];
      else         drv_valid = '0;
    end
    n_vec++;
    if (wr_data_q.size() != 4) begin
      n_err++;
      $display("FAIL single_write_count got %0d, expected 4", wr_data_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_vec++;
        if (wr_data_q[i] !== list[i] || wr_cyc_q[i] != start + 2 + i) begin
          n_err++;
          $display("FAIL single_write_%0d got data=%h cyc=%0d, expected data=%h cyc=%0d",
                   i, wr_data_q[i], wr_cyc_q[i], list[i], start + 2 + i);
        end
      end
    end
    n_vec++;
    if (done_src_q.size() != 2 || done_src_q[0] != 2 || done_src_q[1] != 2) begin
      n_err++;
      $display("FAIL single_word_src got %0d words, expected 2 words from producer 2", done_src_q.size());
    end
  endtask

  task automatic test_alternate();
    int exp_src;
    apply_reset();
    drv_valid = 4'b0011;
    for (int t = 0; t < 11; t++) begin
      drv_data[0] = W'($urandom);
      drv_data[1] = W'($urandom);
      tick();
    end
    drv_valid = '0;
    n_vec++;
    if (wr_src_q.size() < 8 || done_src_q.size() < 4) begin
      n_err++;
      $display("FAIL alternate_count got writes=%0d words=%0d, expected at least 8 and 4",
               wr_src_q.size(), done_src_q.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        exp_src = (i / RATIO) % 2;
        n_vec++;
        if (wr_src_q[i] != exp_src || wr_cyc_q[i] != wr_cyc_q[0] + i) begin
          n_err++;
          $display("FAIL alternate_beat_%0d got src=%0d cyc=%0d, expected src=%0d cyc=%0d",
                   i, wr_src_q[i], wr_cyc_q[i], exp_src, wr_cyc_q[0] + i);
        end
      end
      for (int i = 0; i < 4; i++) begin
        n_vec++;
        if (done_src_q[i] != i % 2) begin
          n_err++;
          $display("FAIL alternate_word_%0d got src=%0d, expected %0d", i, done_src_q[i], i % 2);
        end
      end
    end
  endtask

  task automatic test_full_stall();
    apply_reset();
    drv_valid = 4'b0010;
    drv_data[1] = 16'h1111;
    tick();
    tick();
    drv_data[1] = 16'h2222;
    drv_valid = 4'b0011;
    drv_full = 1'b1;
    for (int t = 0; t < 3; t++) begin
      tick();
      n_vec++;
      if (bus.req_ready !== '0 || bus.fifo_wr_en !== 1'b0) begin
        n_err++;
        $display("FAIL full_hold_%0d got rdy=%b en=%b, expected 0000 0", t, bus.req_ready, bus.fifo_wr_en);
      end
    end
    drv_full = 1'b0;
    tick();
    drv_valid = '0;
    tick();
    n_vec++;
    if (wr_data_q.size() != 2 || wr_data_q[1] !== 16'h2222 || wr_src_q[1] != 1 ||
        done_src_q.size() != 1 || done_src_q[0] != 1) begin
      n_err++;
      $display("FAIL full_resume got writes=%0d words=%0d, expected 2 writes ending 2222 and one word from producer 1",
               wr_data_q.size(), done_src_q.size());
    end
  endtask

  task automatic test_wrap();
    apply_reset();
    drv_valid = 4'b1001;
    tick();
    tick();
    drv_valid = '0;
    tick();
    n_vec++;
    if (wr_src_q.size() < 1 || wr_src_q[0] != 0) begin
      n_err++;
      $display("FAIL wrap_priority got first src=%0d, expected 0",
               (wr_src_q.size() > 0) ? wr_src_q[0] : -1);
    end
  endtask

  task automatic test_reset_mid_burst();
    apply_reset();
    drv_valid = 4'b0100;
    drv_data[2] = 16'h5A5A;
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (bus.req_ready !== '0 || bus.fifo_wr_en !== 1'b0 || bus.word_done !== 1'b0) begin
      n_err++;
      $display("FAIL async_reset got rdy=%b en=%b done=%b, expected 0000 0 0",
               bus.req_ready, bus.fifo_wr_en, bus.word_done);
    end
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    clear_logs();
    drv_valid = 4'b0101;
    drv_data[0] = 16'h0C0C;
    for (int t = 0; t < 4; t++) tick();
    drv_valid = '0;
    n_vec++;
    if (wr_src_q.size() < 2 || wr_src_q[0] != 0 || wr_src_q[1] != 0 ||
        done_src_q.size() < 1 || done_src_q[0] != 0) begin
      n_err++;
      $display("FAIL post_reset_burst got writes=%0d words=%0d, expected two beats and a word from producer 0",
               wr_src_q.size(), done_src_q.size());
    end
  endtask

`ifdef MWSR_ARB_TIMEOUT_EN
  task automatic test_timeout();
    apply_reset();
    drv_valid = 4'b1000;
    drv_data[3] = 16'hBEEF;
    tick();
    tick();
    drv_valid = '0;
    for (int t = 0; t < 8; t++) tick();
    n_vec++;
    if (wr_data_q.size() != 2 || wr_data_q[0] !== 16'hBEEF || wr_data_q[1] !== 16'h0000 ||
        wr_cyc_q[1] - wr_cyc_q[0] != TIMEOUT + 1 || done_src_q.size() != 1 ||
        done_src_q[0] != 3 || done_pad_q[0] != 1'b1) begin
      n_err++;
      $display("FAIL timeout_pad got writes=%0d words=%0d, expected BEEF then 0000 after %0d stalls, padded word from 3",
               wr_data_q.size(), done_src_q.size(), TIMEOUT);
    end
  endtask
`endif

  task automatic test_random();
    apply_reset();
    for (int t = 0; t < 400; t++) begin
      drv_valid = N'($urandom);
      for (int i = 0; i < N; i++) drv_data[i] = W'($urandom);
      drv_full = ($urandom_range(0, 4) == 0);
      tick();
    end
    drv_valid = '0;
    drv_full = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    drv_valid = '0;
    drv_full = 1'b0;
    for (int i = 0; i < N; i++) drv_data[i] = '0;
    model_reset();
    test_reset();
    test_single_producer();
    test_alternate();
    test_full_stall();
    test_wrap();
    test_reset_mid_burst();
`ifdef MWSR_ARB_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
